// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake and payload signals between two pipeline stages
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [REG_W-1:0]  in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_rd;

    // Surrounding stages: drive the upstream entry and the downstream ready
    modport master (
        output in_valid, in_ctrl, in_data, in_rd, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_rd
    );

    // The stage register itself
    modport slave (
        input  in_valid, in_ctrl, in_data, in_rd, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_rd
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with skid buffer, flush and stall counter
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [REG_W-1:0]  main_rd_q,   main_rd_d;

    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [REG_W-1:0]  skid_rd_q,   skid_rd_d;

    logic              out_valid_q;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              acc;
    logic              deq;
    logic              stalled;

    assign acc     = bus.in_valid & in_ready_q;
    assign deq     = out_valid_q & bus.out_ready;
    assign stalled = out_valid_q & ~bus.out_ready;

    // Next-state for the main/skid entries; flush overrides any accept
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d     = ONE;
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                        main_rd_d   = bus.in_rd;
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                        main_rd_d   = bus.in_rd;
                    end else if (acc) begin
                        state_d     = FULL;
                        skid_ctrl_d = bus.in_ctrl;
                        skid_data_d = bus.in_data;
                        skid_rd_d   = bus.in_rd;
                    end else if (deq) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        main_rd_d   = skid_rd_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles the downstream stage held off a valid entry
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, payload and handshake flags; ready/valid are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_rd_q   <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Bubbles carry zero control so they can never write registers or memory
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid_q}};
    assign bus.out_data  = main_data_q;
    assign bus.out_rd    = main_rd_q;
    assign bus.in_ready  = in_ready_q;
    assign stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int CTRL_W = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    int checks;
    int errors;

    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [REG_W-1:0] r, input logic rdy);
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.in_rd     = r;
        bus.out_ready = rdy;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);

        // Reset state
        tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_ctrl",  {28'd0, bus.out_ctrl},  32'd0);
        check("rst_stall_cnt", {28'd0, stall_cnt},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Pass-through stream, one word per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'b1001, 16'(i), 4'(i), 1'b1);
            tick();
            check("pt_valid", {31'd0, bus.out_valid}, 32'd1);
            check("pt_data",  {16'd0, bus.out_data},  32'(i));
            check("pt_ctrl",  {28'd0, bus.out_ctrl},  32'h9);
            check("pt_rd",    {28'd0, bus.out_rd},    32'(i));
        end
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("pt_drain", {31'd0, bus.out_valid}, 32'd0);
        check("pt_no_stall", {28'd0, stall_cnt}, 32'd0);

        // Backpressure with skid fill and in-order drain
        drive(1'b1, 4'b0011, 16'hAAAA, 4'd1, 1'b0);
        tick();
        check("bp_first",   {16'd0, bus.out_data},  32'hAAAA);
        check("bp_ready1",  {31'd0, bus.in_ready},  32'd1);
        drive(1'b1, 4'b0011, 16'hBBBB, 4'd2, 1'b0);
        tick();
        check("bp_full_rdy", {31'd0, bus.in_ready}, 32'd0);
        check("bp_hold1",    {16'd0, bus.out_data}, 32'hAAAA);
        drive(1'b1, 4'b0011, 16'hCCCC, 4'd3, 1'b0);
        tick();
        check("bp_hold2",    {16'd0, bus.out_data}, 32'hAAAA);
        check("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
        check("bp_stall2",   {28'd0, stall_cnt},    32'd2);
        drive(1'b1, 4'b0011, 16'hCCCC, 4'd3, 1'b1);
        tick();
        check("bp_second",  {16'd0, bus.out_data}, 32'hBBBB);
        check("bp_ready2",  {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp_third",   {16'd0, bus.out_data}, 32'hCCCC);
        check("bp_third_rd", {28'd0, bus.out_rd},  32'd3);
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush collides with an accept while FULL
        drive(1'b1, 4'b1111, 16'h1111, 4'd4, 1'b0);
        tick();
        drive(1'b1, 4'b1111, 16'h2222, 4'd5, 1'b0);
        tick();
        check("fl_full", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 4'b1111, 16'hDDDD, 4'd6, 1'b0);
        tick();
        flush = 1'b0;
        check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_ctrl",  {28'd0, bus.out_ctrl},  32'd0);
        check("fl_ready", {31'd0, bus.in_ready},  32'd1);
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();
        check("fl_no_dddd", {31'd0, bus.out_valid}, 32'd0);
        check("fl_stall",   {28'd0, stall_cnt},     32'd4);

        // Bubble: upstream ctrl all ones but nothing offered
        drive(1'b0, 4'b1111, 16'hEEEE, 4'd7, 1'b1);
        tick();
        tick();
        check("bub_ctrl",  {28'd0, bus.out_ctrl},  32'd0);
        check("bub_valid", {31'd0, bus.out_valid}, 32'd0);

        // Stall counter saturation, unaffected by flush
        drive(1'b1, 4'b1111, 16'h5555, 4'd8, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("sat_14", {28'd0, stall_cnt}, 32'd14);
        for (int i = 0; i < 10; i++) tick();
        check("sat_15", {28'd0, stall_cnt}, 32'd15);
        check("sat_hold_data", {16'd0, bus.out_data}, 32'h5555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_after_flush", {28'd0, stall_cnt}, 32'd15);
        check("sat_flush_valid", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, 4'b0101, 16'hAAAA, 4'd1, 1'b0);
        tick();
        drive(1'b1, 4'b0101, 16'hBBBB, 4'd2, 1'b0);
        tick();
        check("ar_full", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_ready", {31'd0, bus.in_ready},  32'd1);
        check("ar_stall", {28'd0, stall_cnt},     32'd0);
        check("ar_ctrl",  {28'd0, bus.out_ctrl},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0110, 16'h1234, 4'd9, 1'b1);
        tick();
        check("ar_first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ar_first_data",  {16'd0, bus.out_data},  32'h1234);
        check("ar_first_ctrl",  {28'd0, bus.out_ctrl},  32'h6);
        drive(1'b0, '0, '0, '0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
